// File: rtl/bank_pkg.sv
// Shared types and default sizes for the register-bank sequencer.
package bank_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_REG_AW = 5;
    localparam int TXN_W          = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        VERIFY,
        READ,
        RESP
    } seqState_t;

endpackage

// File: rtl/bank_sequencer_if.sv
// Host-side request/response handshake of the bank sequencer.
// The master modport is the host; the slave modport is the sequencer.
interface bank_sequencer_if
    import bank_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_AW = DEFAULT_REG_AW
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [REG_AW-1:0] req_reg;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_reg, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_reg, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );

endinterface

// File: rtl/bank_sequencer.sv
// Sequences single host read/write transactions onto a two-read, one-write register bank.
// Define READBACK_VERIFY_EN to read every write back through port B and flag mismatches.
module bank_sequencer
    import bank_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              clock,
    input  logic              clear,
    bank_sequencer_if.slave   host,
    output logic [TXN_W-1:0]  txn_count,
    output logic [REG_AW-1:0] readRegA,
    output logic [REG_AW-1:0] readRegB,
    output logic [REG_AW-1:0] writeReg,
    output logic              readWrite,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] dataReadA,
    input  logic [DATA_W-1:0] dataReadB
);

    seqState_t         state;
    logic              reqReady;
    logic              rspValid;
    logic              rspError;
    logic [DATA_W-1:0] rspData;

    assign host.req_ready = reqReady;
    assign host.rsp_valid = rspValid;
    assign host.rsp_error = rspError;
    assign host.rsp_data  = rspData;

`ifndef READBACK_VERIFY_EN
    logic unusedBankB;
    assign unusedBankB = ^dataReadB;
`endif

    // NOTE: every register here, data path included, is cleared by the async
    // reset so a cut transaction leaves no stale address or data on the bank.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            rspValid  <= 1'b0;
            rspError  <= 1'b0;
            rspData   <= '0;
            txn_count <= '0;
            readRegA  <= '0;
            readRegB  <= '0;
            writeReg  <= '0;
            readWrite <= 1'b0;
            writeData <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every branch sees the
            // pre-edge value of all state and outputs.
            case (state)
                IDLE: begin
                    if (host.req_valid && reqReady) begin
                        reqReady <= 1'b0;
                        if (host.req_write) begin
                            readWrite <= 1'b1;
                            writeReg  <= host.req_reg;
                            writeData <= host.req_data;
                            state     <= WRITE;
                        end else begin
                            readRegA <= host.req_reg;
                            state    <= READ;
                        end
                    end
                end
                WRITE: begin
                    readWrite <= 1'b0;
                    writeReg  <= '0;
                    writeData <= '0;
                    rspData   <= writeData;
                    rspError  <= 1'b0;
`ifdef READBACK_VERIFY_EN
                    readRegB  <= writeReg;
                    state     <= VERIFY;
`else
                    rspValid  <= 1'b1;
                    state     <= RESP;
`endif
                end
`ifdef READBACK_VERIFY_EN
                // rspData already holds the written value; rsp_valid is low here.
                VERIFY: begin
                    readRegB <= '0;
                    rspError <= (dataReadB != rspData);
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
`endif
                READ: begin
                    readRegA <= '0;
                    rspData  <= dataReadA;
                    rspError <= 1'b0;
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (host.rsp_ready) begin
                        rspValid  <= 1'b0;
                        txn_count <= txn_count + 1'b1;
                        reqReady  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_sequencer.sv
// Directed self-checking bench for bank_sequencer with a behavioural register bank.
// Honours READBACK_VERIFY_EN for write latency and the forced read-back mismatch case.
module tb_bank_sequencer;

`ifdef READBACK_VERIFY_EN
    localparam int WR_LAT = 3;
`else
    localparam int WR_LAT = 2;
`endif
    localparam int RD_LAT = 2;

    logic        clock;
    logic        clear;
    logic [15:0] txnCount;
    logic [4:0]  readRegA, readRegB, writeReg;
    logic        readWrite;
    logic [31:0] writeData, dataReadA, dataReadB;

    logic        bankLoad;
    logic        forceZeroB;
    logic [31:0] bankMem [32];
    logic [15:0] expTxn;
    int          passCount;
    int          checkCount;

    bank_sequencer_if #(.DATA_W(32), .REG_AW(5)) bus ();

    bank_sequencer #(.DATA_W(32), .REG_AW(5)) dut (
        .clock     (clock),
        .clear     (clear),
        .host      (bus),
        .txn_count (txnCount),
        .readRegA  (readRegA),
        .readRegB  (readRegB),
        .writeReg  (writeReg),
        .readWrite (readWrite),
        .writeData (writeData),
        .dataReadA (dataReadA),
        .dataReadB (dataReadB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bank model: preset pattern A500_00xx, write on the clock edge, combinational reads.
    always @(posedge clock) begin
        if (bankLoad) begin
            for (int i = 0; i < 32; i++) bankMem[i] <= 32'hA500_0000 | 32'(i);
        end else if (readWrite) begin
            bankMem[writeReg] <= writeData;
        end
    end

    always_comb begin
        dataReadA = bankMem[readRegA];
        dataReadB = forceZeroB ? 32'd0 : bankMem[readRegB];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // One complete transaction: offer, accept, latency, payload, retire.
    task automatic doTxn(input string tag, input logic wr, input logic [4:0] r,
                         input logic [31:0] d, input logic [31:0] expData, input logic expErr);
        int lat;
        int wrPulses;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_reg   = r;
        bus.req_data  = d;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat      = 1;
        wrPulses = 0;
        while (!bus.rsp_valid && lat < 10) begin
            if (readWrite) begin
                wrPulses++;
                check({tag, "_wreg"},  32'(writeReg), 32'(r));
                check({tag, "_wdata"}, writeData, d);
            end
            if (!wr && lat == 1) begin
                check({tag, "_rregA"}, 32'(readRegA), 32'(r));
                check({tag, "_rregB"}, 32'(readRegB), 32'd0);
            end
`ifdef READBACK_VERIFY_EN
            if (wr && lat == 2) check({tag, "_vregB"}, 32'(readRegB), 32'(r));
`endif
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, lat, wr ? WR_LAT : RD_LAT);
        check({tag, "_wpulses"}, wrPulses, wr ? 32'd1 : 32'd0);
        check({tag, "_rdata"}, bus.rsp_data, expData);
        check({tag, "_rerr"}, 32'(bus.rsp_error), 32'(expErr));
        check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        expTxn = expTxn + 16'd1;
        check({tag, "_retired"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_txn"}, 32'(txnCount), 32'(expTxn));
        check({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        passCount     = 0;
        checkCount    = 0;
        expTxn        = 16'd0;
        clear         = 1'b1;
        bankLoad      = 1'b1;
        forceZeroB    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_reg   = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_ready",     32'(bus.req_ready), 32'd1);
        check("rst_readWrite", 32'(readWrite), 32'd0);
        check("rst_rspValid",  32'(bus.rsp_valid), 32'd0);
        check("rst_rspData",   bus.rsp_data, 32'd0);
        check("rst_rspError",  32'(bus.rsp_error), 32'd0);
        check("rst_txn",       32'(txnCount), 32'd0);
        check("rst_addr",      32'({readRegA, readRegB, writeReg}), 32'd0);
        check("rst_wdata",     writeData, 32'd0);
        bankLoad = 1'b0;
        clear    = 1'b0;
        #1 check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        doTxn("wr20",   1'b1, 5'd20, 32'd22,        32'd22,        1'b0);
        doTxn("rd20",   1'b0, 5'd20, 32'd0,         32'd22,        1'b0);
        doTxn("wr3",    1'b1, 5'd3,  32'hDEADBEEF,  32'hDEADBEEF,  1'b0);
        doTxn("rd3",    1'b0, 5'd3,  32'd0,         32'hDEADBEEF,  1'b0);
        doTxn("rd7",    1'b0, 5'd7,  32'd0,         32'hA500_0007, 1'b0);
        doTxn("wr31",   1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        doTxn("wr0",    1'b1, 5'd0,  32'd1,         32'd1,         1'b0);
        doTxn("rd31",   1'b0, 5'd31, 32'd0,         32'hFFFF_FFFF, 1'b0);
        doTxn("rd0",    1'b0, 5'd0,  32'd0,         32'd1,         1'b0);

`ifdef READBACK_VERIFY_EN
        forceZeroB = 1'b1;
        doTxn("vfy5",   1'b1, 5'd5,  32'd5,         32'd5,         1'b1);
        forceZeroB = 1'b0;
        doTxn("rd5",    1'b0, 5'd5,  32'd0,         32'd5,         1'b0);
`endif

        // Response back-pressure with a competing request pending.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_reg   = 5'd20;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_reg   = 5'd3;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_data",  bus.rsp_data, 32'd22);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
            check("bp_regA",  32'(readRegA), 32'd0);
            @(negedge clock);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        expTxn = expTxn + 16'd1;
        check("bp_retired",   32'(bus.rsp_valid), 32'd0);
        check("bp_txn",       32'(txnCount), 32'(expTxn));
        check("bp_no_accept", 32'(readRegA), 32'd0);
        check("bp_idle",      32'(bus.req_ready), 32'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("bp_accept_regA", 32'(readRegA), 32'd3);
        @(negedge clock);
        check("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_next_data",  bus.rsp_data, 32'hDEADBEEF);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        expTxn = expTxn + 16'd1;
        check("bp_next_txn", 32'(txnCount), 32'(expTxn));

        // Clear landing in the middle of a WRITE cycle.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_reg   = 5'd9;
        bus.req_data  = 32'h99;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("clr_wr_active", 32'(readWrite), 32'd1);
        #1 clear = 1'b1;
        #1;
        check("clr_readWrite", 32'(readWrite), 32'd0);
        check("clr_rspValid",  32'(bus.rsp_valid), 32'd0);
        check("clr_txn",       32'(txnCount), 32'd0);
        check("clr_wreg",      32'(writeReg), 32'd0);
        @(negedge clock);
        clear  = 1'b0;
        expTxn = 16'd0;
        #1 check("clr_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        check("clr_no_rsp", 32'(bus.rsp_valid), 32'd0);
        doTxn("clr_rd9", 1'b0, 5'd9, 32'd0, 32'hA500_0009, 1'b0);

        // Counter wrap: preload near the top, then two reads.
        @(negedge clock);
        force dut.txn_count = 16'hFFFE;
        @(negedge clock);
        release dut.txn_count;
        expTxn = 16'hFFFE;
        doTxn("wrap_a", 1'b0, 5'd20, 32'd0, 32'd22, 1'b0);
        doTxn("wrap_b", 1'b0, 5'd20, 32'd0, 32'd22, 1'b0);
        check("wrap_zero", 32'(txnCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
